// File: rtl/i2s_mix_pkg.sv
// Shared definitions for the N-lane I2S mixer: word-select side encoding,
// the supported lane limit and the signed clamp used by the saturating mix.
package i2s_mix_pkg;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;
  localparam int   MAX_LANES  = 8;

  // Clamp a signed value into the two's complement range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/i2s_rx_lane.sv
// One I2S input lane: assembles the serial word MSB first into a left-aligned
// register and commits it to the left or right holding register when the
// top level signals a word-select edge. Bit position and edge come from the
// shared counter in the top level.
module i2s_rx_lane
  import i2s_mix_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             sck,
  input  logic             reset_n,
  input  logic             sd_i,
  input  logic             edge_i,
  input  logic             side_i,
  input  logic [CNT_W-1:0] bit_cnt_i,
  output logic [WIDTH-1:0] hold_left_o,
  output logic [WIDTH-1:0] hold_right_o
);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] hold_left_q, hold_right_q;

  // Place the current bit at WIDTH-1-bit_cnt; a saturated counter matches no bit.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt_i == CNT_W'(WIDTH - 1 - i)) asm_d[i] = sd_i;
    end
  end

  // On an edge the word (including this cycle's last bit) is committed and assembly restarts.
  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      asm_q        <= '0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
    end else if (edge_i) begin
      asm_q <= '0;
      if (side_i == SIDE_LEFT) hold_left_q  <= asm_d;
      else                     hold_right_q <= asm_d;
    end else begin
      asm_q <= asm_d;
    end
  end

  assign hold_left_o  = hold_left_q;
  assign hold_right_o = hold_right_q;

endmodule

// File: rtl/i2s_mixer_nch.sv
// N-lane I2S receiver/mixer. Lanes share sck and ws; the enabled lanes are
// summed per side as signed values and re-serialised on the falling edge with
// one frame of latency. Build option MIX_SAT_EN selects a clamped sum with a
// clip pulse; without it the sum is arithmetically shifted down by SUM_SHIFT.
module i2s_mixer_nch
  import i2s_mix_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int WIDTH     = 24,
  parameter int CNT_W     = $clog2(WIDTH + 1),
  parameter int SUM_SHIFT = $clog2(N_IN)
) (
  input  logic            sck,
  input  logic            reset_n,
  input  logic            ws,
  input  logic [N_IN-1:0] sd_in,
  input  logic [N_IN-1:0] ch_en,
  output logic            sd_out,
  output logic            ws_out,
  output logic            frame_strobe,
  output logic            clip
);

  localparam int               SUM_W   = WIDTH + SUM_SHIFT;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic             ws_q;
  logic             ws_edge;
  logic             load_q;
  logic             fs_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic [N_IN-1:0][WIDTH-1:0] hold_l;
  logic [N_IN-1:0][WIDTH-1:0] hold_r;

  logic signed [SUM_W-1:0] sum;
  logic signed [WIDTH-1:0] lane_word;
  logic [WIDTH-1:0]        out_word;

  logic [WIDTH-1:0] shift_q;
  logic             sd_out_q;
  logic             ws_out_q;

  assign ws_edge = ws ^ ws_q;

  // Bit position restarts on every ws edge and stops counting once the word is full.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (ws_edge)                  bit_cnt_d = '0;
    else if (bit_cnt_q < CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
  end

  // Rising-edge control: ws history, bit counter, load request and frame strobe.
  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      ws_q      <= 1'b0;
      bit_cnt_q <= '0;
      load_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      ws_q      <= ws;
      bit_cnt_q <= bit_cnt_d;
      load_q    <= ws_edge;
      fs_q      <= ws_edge & ws_q;
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_lane
    i2s_rx_lane #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_lane (
      .sck         (sck),
      .reset_n     (reset_n),
      .sd_i        (sd_in[k]),
      .edge_i      (ws_edge),
      .side_i      (ws_q),
      .bit_cnt_i   (bit_cnt_q),
      .hold_left_o (hold_l[k]),
      .hold_right_o(hold_r[k])
    );
  end

  // Signed sum of the enabled lanes for the side of the slot now starting.
  always_comb begin
    sum       = '0;
    lane_word = '0;
    for (int k = 0; k < N_IN; k++) begin
      lane_word = (ws_q == SIDE_RIGHT) ? hold_r[k] : hold_l[k];
      if (ch_en[k] && (k < MAX_LANES)) sum = sum + SUM_W'(lane_word);
    end
  end

`ifdef MIX_SAT_EN
  logic signed [63:0] sum_ext;
  logic signed [63:0] clamped;
  logic               sat_hit;
  logic               clip_q;

  assign sum_ext  = 64'(sum);
  assign clamped  = sat_clamp(sum_ext, WIDTH);
  assign out_word = WIDTH'(clamped);
  assign sat_hit  = (clamped != sum_ext);

  // Clip flags the word just loaded and lasts a single bit period.
  always_ff @(negedge sck or negedge reset_n) begin
    if (!reset_n) clip_q <= 1'b0;
    else          clip_q <= load_q & sat_hit;
  end

  assign clip = clip_q;
`else
  assign out_word = WIDTH'(sum >>> SUM_SHIFT);
  assign clip     = 1'b0;
`endif

  // Falling-edge output: load the mix after an edge, otherwise shift out MSB first with zero fill.
  always_ff @(negedge sck or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      sd_out_q <= 1'b0;
      ws_out_q <= 1'b0;
    end else if (load_q) begin
      sd_out_q <= out_word[WIDTH-1];
      shift_q  <= {out_word[WIDTH-2:0], 1'b0};
      ws_out_q <= ws_q;
    end else begin
      sd_out_q <= shift_q[WIDTH-1];
      shift_q  <= {shift_q[WIDTH-2:0], 1'b0};
    end
  end

  assign sd_out       = sd_out_q;
  assign ws_out       = ws_out_q;
  assign frame_strobe = fs_q;

endmodule

// File: tb/tb_i2s_mixer_nch.sv
// Self-checking bench for i2s_mixer_nch: slot-level programs of I2S words are
// transmitted on two lanes and the serial output is compared per slot against
// a frame-level arithmetic model of the mix.
module tb_i2s_mixer_nch;

  localparam int N_IN      = 2;
  localparam int WIDTH     = 24;
  localparam int SUM_SHIFT = $clog2(N_IN);
  localparam int MAXS      = 40;

  logic            sck = 1'b0;
  logic            reset_n;
  logic            ws;
  logic [N_IN-1:0] sd_in;
  logic [N_IN-1:0] ch_en;
  logic            sd_out;
  logic            ws_out;
  logic            frame_strobe;
  logic            clip;

  always #5 sck = ~sck;

  i2s_mixer_nch #(
    .N_IN (N_IN),
    .WIDTH(WIDTH)
  ) dut (
    .sck         (sck),
    .reset_n     (reset_n),
    .ws          (ws),
    .sd_in       (sd_in),
    .ch_en       (ch_en),
    .sd_out      (sd_out),
    .ws_out      (ws_out),
    .frame_strobe(frame_strobe),
    .clip        (clip)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slot program: one preamble right slot followed by left/right pairs.
  int              nslots;
  int              slot_len  [MAXS];
  logic            slot_side [MAXS];
  logic [31:0]     slot_w    [MAXS][N_IN];
  logic [N_IN-1:0] slot_en   [MAXS];
  logic [63:0]     got_word  [MAXS];
  logic            got_clip  [MAXS];

  // Words the model believes each lane last received per side.
  logic [WIDTH-1:0] m_hold_l [N_IN];
  logic [WIDTH-1:0] m_hold_r [N_IN];

  int len_tab [9] = '{24, 24, 32, 16, 20, 8, 1, 2, 31};

  task automatic clear_model();
    for (int k = 0; k < N_IN; k++) begin
      m_hold_l[k] = '0;
      m_hold_r[k] = '0;
    end
  endtask

  // Word as received: first min(len, WIDTH) bits sent, left aligned.
  function automatic logic [WIDTH-1:0] received(input logic [31:0] w, input int len);
    logic [63:0] v;
    v = {32'd0, w} & ((64'd1 << len) - 64'd1);
    if (len <= WIDTH) return WIDTH'(v << (WIDTH - len));
    return WIDTH'(v >> (len - WIDTH));
  endfunction

  function automatic longint as_signed(input logic [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] s;
    s = x;
    return longint'(s);
  endfunction

  task automatic mix_model(input logic side, input logic [N_IN-1:0] en,
                           output logic [WIDTH-1:0] word, output logic clipped);
    longint sum;
    longint hi;
    longint lo;
    sum = 0;
    for (int k = 0; k < N_IN; k++)
      if (en[k]) sum += as_signed(side ? m_hold_r[k] : m_hold_l[k]);
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -hi - 1;
`ifdef MIX_SAT_EN
    clipped = (sum > hi) || (sum < lo);
    if (sum > hi) sum = hi;
    if (sum < lo) sum = lo;
`else
    clipped = 1'b0;
    sum = sum >>> SUM_SHIFT;
`endif
    word = WIDTH'(sum);
  endtask

  task automatic set_slot(input int s, input logic side, input int len,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [N_IN-1:0] en);
    slot_side[s] = side;
    slot_len[s]  = len;
    slot_w[s][0] = w0;
    slot_w[s][1] = w1;
    slot_en[s]   = en;
  endtask

  task automatic build_random(input int nframes);
    set_slot(0, 1'b1, WIDTH, 32'd0, 32'd0, N_IN'($urandom));
    for (int f = 0; f < nframes; f++) begin
      set_slot(1 + 2 * f, 1'b0, len_tab[$urandom_range(0, 8)], $urandom, $urandom, N_IN'($urandom));
      set_slot(2 + 2 * f, 1'b1, len_tab[$urandom_range(0, 8)], $urandom, $urandom, N_IN'($urandom));
    end
    nslots = 1 + 2 * nframes;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sd_in = '0;
      ch_en = N_IN'($urandom);
      @(posedge sck); #3;
    end
  endtask

  // Transmit the program and compare each output slot with the model.
  task automatic play();
    logic [WIDTH-1:0] exp_word;
    logic             exp_clip;
    logic [63:0]      got;
    logic [63:0]      exp_bits;
    int               len;
    int               fs_seen;
    int               clip_seen;
    int               n_right;
    int               n_clip;
    fs_seen = 0; clip_seen = 0; n_right = 0; n_clip = 0;
    // Lead-in cycle: the ws edge that opens the preamble carries a zero bit.
    ws = slot_side[0];
    sd_in = '0;
    ch_en = N_IN'($urandom);
    @(posedge sck); #1;
    if (frame_strobe) fs_seen++;
    #2;
    for (int k = 0; k < N_IN; k++) begin
      if (slot_side[0]) m_hold_l[k] = '0;
      else              m_hold_r[k] = '0;
    end
    for (int s = 0; s < nslots; s++) begin
      len = slot_len[s];
      mix_model(slot_side[s], slot_en[s], exp_word, exp_clip);
      got = '0;
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) ws = (s + 1 < nslots) ? slot_side[s + 1] : ~slot_side[s];
        else              ws = slot_side[s];
        for (int k = 0; k < N_IN; k++) sd_in[k] = slot_w[s][k][len - 1 - i];
        ch_en = (i == 0) ? slot_en[s] : N_IN'($urandom);
        @(posedge sck); #1;
        got = {got[62:0], sd_out};
        if (i == 0) begin
          check_eq("ws_out", 64'(ws_out), 64'(slot_side[s]));
          check_eq("clip", 64'(clip), 64'(exp_clip));
          got_clip[s] = clip;
        end
        if (clip) clip_seen++;
        if (frame_strobe) fs_seen++;
        if (i == len - 1 && slot_side[s]) check_eq("fs_pulse", 64'(frame_strobe), 64'd1);
        #2;
      end
      if (len <= WIDTH) exp_bits = {40'd0, exp_word} >> (WIDTH - len);
      else              exp_bits = {40'd0, exp_word} << (len - WIDTH);
      got_word[s] = got;
      check_eq($sformatf("sd_word[%0d]", s), got, exp_bits);
      for (int k = 0; k < N_IN; k++) begin
        if (slot_side[s]) m_hold_r[k] = received(slot_w[s][k], len);
        else              m_hold_l[k] = received(slot_w[s][k], len);
      end
      if (slot_side[s]) n_right++;
      if (exp_clip) n_clip++;
    end
    check_eq("fs_count", 64'(fs_seen), 64'(n_right));
    check_eq("clip_count", 64'(clip_seen), 64'(n_clip));
    idle(WIDTH + 8);
  endtask

  // Assert reset part-way through a right word and check the outputs clear at once.
  task automatic reset_mid_word();
    ws = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sd_in = N_IN'($urandom);
      ch_en = '1;
      @(posedge sck); #3;
    end
    check_eq("pre_rst_ws_out", 64'(ws_out), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_sd_out", 64'(sd_out), 64'd0);
    check_eq("rst_ws_out", 64'(ws_out), 64'd0);
    check_eq("rst_frame_strobe", 64'(frame_strobe), 64'd0);
    check_eq("rst_clip", 64'(clip), 64'd0);
    clear_model();
    repeat (2) @(posedge sck);
    #3;
    ws = 1'b0;
    sd_in = '0;
    reset_n = 1'b1;
    idle(WIDTH + 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    ws = 1'b0;
    sd_in = '0;
    ch_en = '0;
    clear_model();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst0_sd_out", 64'(sd_out), 64'd0);
    check_eq("rst0_ws_out", 64'(ws_out), 64'd0);
    check_eq("rst0_frame_strobe", 64'(frame_strobe), 64'd0);
    check_eq("rst0_clip", 64'(clip), 64'd0);
    repeat (3) @(posedge sck);
    #3;
    reset_n = 1'b1;
    idle(WIDTH + 4);

    // Directed program: spec mix cases, short and long slots, full-scale words.
    set_slot(0,  1'b1, 24, 32'h0,        32'h0,        2'b11);
    set_slot(1,  1'b0, 24, 32'h100000,   32'h200000,   2'b11);
    set_slot(2,  1'b1, 24, 32'hFFFFFE,   32'h7FFFFF,   2'b11);
    set_slot(3,  1'b0, 24, $urandom,     $urandom,     2'b11);
    set_slot(4,  1'b1, 24, $urandom,     $urandom,     2'b01);
    set_slot(5,  1'b0, 16, 32'hABCD,     32'hABCD,     N_IN'($urandom));
    set_slot(6,  1'b1, 32, 32'h12345678, 32'h12345678, N_IN'($urandom));
    set_slot(7,  1'b0, 24, 32'h7FFFFF,   32'h7FFFFF,   2'b11);
    set_slot(8,  1'b1, 24, 32'h800000,   32'h800000,   2'b11);
    set_slot(9,  1'b0, 24, $urandom,     $urandom,     2'b11);
    set_slot(10, 1'b1, 24, $urandom,     $urandom,     2'b11);
    nslots = 11;
    play();
`ifdef MIX_SAT_EN
    check_eq("dir_left_mix",  got_word[3],  64'h300000);
    check_eq("dir_right_en01", got_word[4], 64'hFFFFFE);
    check_eq("dir_16bit",     got_word[7],  64'h800000);
    check_eq("dir_16bit_clip", 64'(got_clip[7]), 64'd1);
    check_eq("dir_32bit",     got_word[8],  64'h2468AC);
    check_eq("dir_pos_full",  got_word[9],  64'h7FFFFF);
    check_eq("dir_pos_clip",  64'(got_clip[9]), 64'd1);
    check_eq("dir_neg_full",  got_word[10], 64'h800000);
    check_eq("dir_neg_clip",  64'(got_clip[10]), 64'd1);
`else
    check_eq("dir_left_mix",  got_word[3],  64'h180000);
    check_eq("dir_right_en01", got_word[4], 64'hFFFFFF);
    check_eq("dir_16bit",     got_word[7],  64'hABCD00);
    check_eq("dir_32bit",     got_word[8],  64'h123456);
    check_eq("dir_pos_full",  got_word[9],  64'h7FFFFF);
    check_eq("dir_pos_clip",  64'(got_clip[9]), 64'd0);
    check_eq("dir_neg_full",  got_word[10], 64'h800000);
    check_eq("dir_neg_clip",  64'(got_clip[10]), 64'd0);
`endif

    // Random frames with mixed slot lengths and enables.
    build_random(8);
    play();

    // Reset in the middle of a right word, then the first frame must be silent.
    reset_mid_word();
    build_random(4);
    play();
    check_eq("post_rst_pre",   got_word[0], 64'd0);
    check_eq("post_rst_left",  got_word[1], 64'd0);
    check_eq("post_rst_right", got_word[2], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
